// File: rtl/my_mul16_seq_if.sv
// Operand/result handshake bundle for the sequential 16-bit multiplier.
// Vectors use [0:W-1]: index 0 is the most significant bit.
interface my_mul16_seq_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [0:WIDTH-1] a;
   logic [0:WIDTH-1] b;
   logic             out_valid;
   logic             out_ready;
   logic [0:WIDTH-1] product;
   logic             ovf;

   modport slave (
      input  in_valid,
      input  a,
      input  b,
      input  out_ready,
      output in_ready,
      output out_valid,
      output product,
      output ovf
   );

   modport master (
      output in_valid,
      output a,
      output b,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  product,
      input  ovf
   );
endinterface

// File: rtl/my_mul16_seq.sv
// Shift-and-add 16x16 multiplier: low 16 product bits plus overflow flag.
// Vectors use [0:W-1] so index W-1 is the least significant bit.
module my_mul16_seq_rca #(
   parameter int WIDTH = 16
) (
   input  logic [0:WIDTH-1] a_i,
   input  logic [0:WIDTH-1] b_i,
   output logic [0:WIDTH-1] sum_o,
   output logic             cout_o
);
   always_comb begin
      logic carry;
      carry = 1'b0;
      sum_o = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
         sum_o[i] = a_i[i] ^ b_i[i] ^ carry;
         carry    = (a_i[i] & b_i[i]) | (carry & (a_i[i] ^ b_i[i]));
      end
      cout_o = carry;
   end
endmodule

module my_mul16_seq #(
   parameter int WIDTH = 16,
   parameter int ITER  = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   my_mul16_seq_if.slave  bus
);
   localparam int CW = $clog2(ITER);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      HOLD = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [0:WIDTH-1] mcand_q, mcand_d;
   logic [0:WIDTH-1] mplier_q, mplier_d;
   logic [0:WIDTH-1] acc_q, acc_d;
   logic [0:WIDTH-1] product_q, product_d;
   logic             lost_q, lost_d;
   logic             ovf_q, ovf_d;
   logic [CW-1:0]    cnt_q, cnt_d;

   logic [0:WIDTH-1] sum;
   logic             cout;
   logic             mplier_lsb;
   logic             mplier_upper_nz;
   logic             mcand_msb;

   my_mul16_seq_rca #(.WIDTH(WIDTH)) u_add (
      .a_i    (acc_q),
      .b_i    (mcand_q),
      .sum_o  (sum),
      .cout_o (cout)
   );

   assign mplier_lsb      = mplier_q[WIDTH-1];
   assign mplier_upper_nz = |mplier_q[0:WIDTH-2];
   assign mcand_msb       = mcand_q[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         mcand_q   <= '0;
         mplier_q  <= '0;
         acc_q     <= '0;
         product_q <= '0;
         lost_q    <= 1'b0;
         ovf_q     <= 1'b0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         mcand_q   <= mcand_d;
         mplier_q  <= mplier_d;
         acc_q     <= acc_d;
         product_q <= product_d;
         lost_q    <= lost_d;
         ovf_q     <= ovf_d;
         cnt_q     <= cnt_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      mcand_d   = mcand_q;
      mplier_d  = mplier_q;
      acc_d     = acc_q;
      product_d = product_q;
      lost_d    = lost_q;
      ovf_d     = ovf_q;
      cnt_d     = cnt_q;
      unique case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               mcand_d  = bus.a;
               mplier_d = bus.b;
               acc_d    = '0;
               lost_d   = 1'b0;
               cnt_d    = '0;
               state_d  = RUN;
            end
         end
         RUN: begin
            if (mplier_lsb) begin
               acc_d  = sum;
               lost_d = lost_q | cout;
            end
            // a dropped mcand bit matters only if a later mplier bit adds it
            if (mcand_msb && mplier_upper_nz) lost_d = 1'b1;
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == CW'(ITER - 1)) begin
               product_d = acc_d;
               ovf_d     = lost_d;
               state_d   = HOLD;
            end
         end
         HOLD: begin
            if (bus.out_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == HOLD);
   assign bus.product   = product_q;
   assign bus.ovf       = ovf_q;
endmodule

// File: tb/tb_my_mul16_seq.sv
// Directed bench for my_mul16_seq with a timestamp-based reference model.
module tb_my_mul16_seq;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;
   logic [16:0] log_q[$];

   my_mul16_seq_if bus ();

   my_mul16_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] got,
                      input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, got, exp);
      end
   endtask

   function automatic logic [16:0] ref_mul(input logic [15:0] x,
                                           input logic [15:0] y);
      logic [31:0] p;
      p = {16'd0, x} * {16'd0, y};
      return {p >= 32'd65536, p[15:0]};
   endfunction

   // Model: an accepted op yields its result 17 falling edges later
   initial begin
      bit          busy = 0;
      int          ncnt = 0;
      int          due = 0;
      logic [16:0] cur = '0;
      logic [16:0] last = '0;
      logic        ov_exp;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            busy = 0;
            last = '0;
            chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
            chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
            chk("rst_product", 32'(bus.product), 32'd0);
            chk("rst_ovf", 32'(bus.ovf), 32'd0);
         end else begin
            ncnt++;
            ov_exp = busy && (ncnt >= due);
            chk("in_ready", 32'(bus.in_ready), 32'(!busy));
            chk("out_valid", 32'(bus.out_valid), 32'(ov_exp));
            chk("product", 32'(bus.product),
                32'(ov_exp ? cur[15:0] : last[15:0]));
            chk("ovf", 32'(bus.ovf), 32'(ov_exp ? cur[16] : last[16]));
            if (ov_exp && bus.out_ready) begin
               busy = 0;
               last = cur;
               log_q.push_back({bus.ovf, 16'(bus.product)});
            end else if (!busy && bus.in_valid) begin
               busy = 1;
               due  = ncnt + 17;
               cur  = ref_mul(16'(bus.a), 16'(bus.b));
            end
         end
      end
   end

   task automatic expect_log(input string nm, input logic [15:0] p,
                             input logic o);
      if (log_q.size() == 0) begin
         chk({nm, "_missing"}, 32'd0, 32'd1);
      end else begin
         logic [16:0] e;
         e = log_q.pop_front();
         chk({nm, "_prod"}, 32'(e[15:0]), 32'(p));
         chk({nm, "_ovf"}, 32'(e[16]), 32'(o));
      end
   endtask

   task automatic wait_accept(input string nm);
      bit ok = 0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(negedge clk);
         if (bus.in_ready) ok = 1;
      end
      if (!ok) chk({nm, "_accept_timeout"}, 32'd0, 32'd1);
      @(posedge clk);
      #2;
   endtask

   task automatic wait_log(input string nm, input int n);
      bit ok = 0;
      for (int i = 0; i < 100 && !ok; i++) begin
         @(negedge clk);
         if (log_q.size() >= n) ok = 1;
      end
      if (!ok) chk({nm, "_result_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic run_op(input string nm, input logic [15:0] av,
                         input logic [15:0] bv, input int hold,
                         input bit pulse);
      bus.a = av;
      bus.b = bv;
      bus.in_valid = 1'b1;
      bus.out_ready = (hold == 0);
      wait_accept(nm);
      bus.in_valid = 1'b0;
      if (hold > 0) begin
         bit ok = 0;
         for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (bus.out_valid) ok = 1;
         end
         if (!ok) chk({nm, "_valid_timeout"}, 32'd0, 32'd1);
         for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #2;
            bus.in_valid = pulse && (i == 1);
         end
         @(posedge clk);
         #2;
         bus.in_valid = 1'b0;
         bus.out_ready = 1'b1;
      end
      wait_log(nm, 1);
      @(posedge clk);
      #2;
      bus.out_ready = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b0;
      bus.a = '0;
      bus.b = '0;
      repeat (3) @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #2;

      run_op("basic", 16'd3, 16'd5, 0, 0);
      expect_log("basic", 16'd15, 1'b0);
      run_op("edge60000", 16'd300, 16'd200, 0, 0);
      expect_log("edge60000", 16'hEA60, 1'b0);
      run_op("wrap0", 16'd256, 16'd256, 0, 0);
      expect_log("wrap0", 16'd0, 1'b1);
      run_op("ffff", 16'hFFFF, 16'hFFFF, 0, 0);
      expect_log("ffff", 16'd1, 1'b1);
      run_op("b_one", 16'hABCD, 16'd1, 0, 0);
      expect_log("b_one", 16'hABCD, 1'b0);
      run_op("a_zero", 16'd0, 16'hFFFF, 0, 0);
      expect_log("a_zero", 16'd0, 1'b0);
      run_op("backpressure", 16'd7, 16'd9, 5, 1);
      expect_log("backpressure", 16'd63, 1'b0);

      bus.a = 16'd9;
      bus.b = 16'd11;
      bus.in_valid = 1'b1;
      wait_accept("abort");
      bus.in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      chk("abort_in_ready", 32'(bus.in_ready), 32'd1);
      chk("abort_out_valid", 32'(bus.out_valid), 32'd0);
      chk("abort_product", 32'(bus.product), 32'd0);
      chk("abort_ovf", 32'(bus.ovf), 32'd0);
      repeat (2) @(posedge clk);
      #2;
      rst_n = 1'b1;
      chk("abort_no_result", 32'(log_q.size()), 32'd0);
      @(posedge clk);
      #2;
      run_op("post_reset", 16'd2, 16'd2, 0, 0);
      expect_log("post_reset", 16'd4, 1'b0);

      bus.out_ready = 1'b1;
      bus.a = 16'd1;
      bus.b = 16'd1;
      bus.in_valid = 1'b1;
      wait_accept("stream0");
      bus.a = 16'd0;
      bus.b = 16'd1234;
      wait_accept("stream1");
      bus.a = 16'h8000;
      bus.b = 16'd2;
      wait_accept("stream2");
      bus.in_valid = 1'b0;
      wait_log("stream", 3);
      @(posedge clk);
      #2;
      bus.out_ready = 1'b0;
      expect_log("stream0", 16'd1, 1'b0);
      expect_log("stream1", 16'd0, 1'b0);
      expect_log("stream2", 16'd0, 1'b1);

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
